// File: rtl/mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// mult_product_accumulator
//
// Consumer stage that sits after the 4x4 multiplier core. It sums groups of up
// to LEN unsigned products into a saturating ACC_W-bit accumulator and emits
// one result per group.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and the payload
// stable until that edge. Ready may depend on the receiver's state, but
// never on valid. Here, in_ready depends only on state and rst_n, and out_*
// are driven straight from registers.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   clear      in   1       synchronous abort of partial group / pending result
//   in_valid   in   1       product beat valid
//   in_ready   out  1       stage can accept a beat (ACC state and not in reset)
//   in_prod    in   PROD_W  unsigned product
//   in_last    in   1       beat closes the group early
//   out_valid  out  1       result valid, held until accepted
//   out_ready  in   1       downstream accepts result
//   out_sum    out  ACC_W   saturated group sum
//   out_count  out  CNT_W   beats summed into out_sum (1..LEN)
//   out_ovf    out  1       some add in the group saturated
//   dbg_state  out  1       FSM state for observation (0 = ACC, 1 = OUT)
// -----------------------------------------------------------------------------
module mult_product_accumulator #(
  parameter  int PROD_W = 8,
  parameter  int ACC_W  = 12,
  parameter  int LEN    = 4,
  localparam int CNT_W  = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              dbg_state
);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               oovf_q, oovf_d;

  logic               beat;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_nx;
  logic               ovf_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               close;

  assign in_ready  = (state_q == S_ACC) & rst_n;
  assign beat      = in_valid & in_ready;

  // One extra bit catches the carry out. Once the accumulator is all-ones,
  // any non-zero product carries out again, so saturation stays sticky.
  assign sum_wide  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign acc_nx    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign ovf_nx    = ovf_q | sum_wide[ACC_W];
  assign cnt_nx    = cnt_q + CNT_W'(1);
  assign close     = (cnt_nx == CNT_W'(LEN)) | in_last;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      S_ACC: begin
        if (beat) begin
          if (close) begin
            sum_d   = acc_nx;
            count_d = cnt_nx;
            oovf_d  = ovf_nx;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            acc_d   = acc_nx;
            cnt_d   = cnt_nx;
            ovf_d   = ovf_nx;
          end
        end
      end
      S_OUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // Reset and clear have the same effect on state; only in_ready differs,
  // and that is handled combinationally above.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = oovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// Bench for mult_product_accumulator. Three instances cover the default
// configuration (LEN=4, ACC_W=12), a narrow accumulator (ACC_W=9), and
// single-beat groups (LEN=1). One instance is exercised at a time through a
// select variable. The reference model keeps the accepted beats of the open
// group. When the group closes, it sums them with plain integer arithmetic
// and clips the total to the accumulator maximum.
// -----------------------------------------------------------------------------
module tb_mult_product_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_prod;
  int         sel;

  logic        a_ir, a_ov, a_ovf, a_st;  logic [11:0] a_sum; logic [2:0] a_cnt;
  logic        b_ir, b_ov, b_ovf, b_st;  logic [8:0]  b_sum; logic [2:0] b_cnt;
  logic        c_ir, c_ov, c_ovf, c_st;  logic [11:0] c_sum; logic [0:0] c_cnt;

  logic a_v, b_v, c_v, a_r, b_r, c_r;
  assign a_v = in_valid & (sel == 0);
  assign b_v = in_valid & (sel == 1);
  assign c_v = in_valid & (sel == 2);
  assign a_r = (sel == 0) ? out_ready : 1'b1;
  assign b_r = (sel == 1) ? out_ready : 1'b1;
  assign c_r = (sel == 2) ? out_ready : 1'b1;

  mult_product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(a_v), .in_ready(a_ir),
    .in_prod(in_prod), .in_last(in_last), .out_valid(a_ov), .out_ready(a_r),
    .out_sum(a_sum), .out_count(a_cnt), .out_ovf(a_ovf), .dbg_state(a_st));
  mult_product_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(b_v), .in_ready(b_ir),
    .in_prod(in_prod), .in_last(in_last), .out_valid(b_ov), .out_ready(b_r),
    .out_sum(b_sum), .out_count(b_cnt), .out_ovf(b_ovf), .dbg_state(b_st));
  mult_product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(c_v), .in_ready(c_ir),
    .in_prod(in_prod), .in_last(in_last), .out_valid(c_ov), .out_ready(c_r),
    .out_sum(c_sum), .out_count(c_cnt), .out_ovf(c_ovf), .dbg_state(c_st));

  // Observed signals of the selected instance.
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_sum;
  logic [2:0]  out_count;
  always_comb begin
    in_ready = a_ir; out_valid = a_ov; out_ovf = a_ovf; out_sum = a_sum; out_count = a_cnt;
    if (sel == 1) begin
      in_ready = b_ir; out_valid = b_ov; out_ovf = b_ovf;
      out_sum = {3'b000, b_sum}; out_count = b_cnt;
    end else if (sel == 2) begin
      in_ready = c_ir; out_valid = c_ov; out_ovf = c_ovf;
      out_sum = c_sum; out_count = {2'b00, c_cnt};
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int grp_q[$];            // accepted beats of the open group
  logic [15:0] exp_q[$];   // pending result: {ovf, count[2:0], sum[11:0]}

  function automatic int cfg_len();
    return (sel == 2) ? 1 : 4;
  endfunction
  function automatic int cfg_max();
    return (sel == 1) ? 511 : 4095;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge. Drives one cycle of inputs, checks
  // in_ready, lets the rising edge happen, and updates the model. It then
  // checks the outputs at the next falling edge.
  task automatic cycle(input bit v, input int p, input bit l, input bit r);
    bit exp_ir, acc, hs;
    int total, mx;
    in_valid  = v;
    in_prod   = 8'(p);
    in_last   = l;
    out_ready = r;
    #1;
    exp_ir = rst_n && (exp_q.size() == 0);
    check("in_ready", in_ready, exp_ir);
    acc = v && exp_ir;
    hs  = (exp_q.size() != 0) && r;
    @(posedge clk);
    if (!rst_n || clear) begin
      grp_q.delete();
      exp_q.delete();
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (acc) begin
        grp_q.push_back(p & 255);
        if (grp_q.size() == cfg_len() || l) begin
          total = 0;
          foreach (grp_q[i]) total += grp_q[i];
          mx = cfg_max();
          exp_q.push_back({(total > mx), 3'(grp_q.size()), 12'((total > mx) ? mx : total)});
          grp_q.delete();
        end
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_sum",   out_sum,   exp_q[0][11:0]);
      check("out_count", out_count, exp_q[0][14:12]);
      check("out_ovf",   out_ovf,   exp_q[0][15]);
    end
  endtask

  task automatic do_reset(input int s);
    sel = s; rst_n = 1'b0; clear = 1'b0;
    cycle(0, 0, 0, 1);
    rst_n = 1'b1;
    check("rst_sum",   out_sum,   0);
    check("rst_count", out_count, 0);
    check("rst_ovf",   out_ovf,   0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      clear = ($urandom_range(0, 49) == 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    clear = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    sel = 0; rst_n = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Default configuration: four full beats of 225.
    do_reset(0);
    for (int i = 0; i < 4; i++) cycle(1, 225, 0, 0);
    check("t1_sum", out_sum, 900);
    check("t1_count", out_count, 4);
    check("t1_ovf", out_ovf, 0);
    // Result held with out_ready low; offered beats are refused.
    for (int i = 0; i < 5; i++) cycle(1, $urandom_range(0, 255), 0, 0);
    check("t4_hold_sum", out_sum, 900);
    cycle(0, 0, 0, 1);
    check("t4_released", out_valid, 0);

    // Early close with in_last.
    cycle(1, 3, 0, 1);
    cycle(1, 5, 1, 1);
    check("t2_sum", out_sum, 8);
    check("t2_count", out_count, 2);
    cycle(0, 0, 0, 1);

    // Clear drops a partial group.
    cycle(1, 10, 0, 1);
    cycle(1, 20, 0, 1);
    clear = 1'b1; cycle(0, 0, 0, 1); clear = 1'b0;
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 1);
    check("t5_sum", out_sum, 10);
    check("t5_count", out_count, 4);
    cycle(0, 0, 0, 1);
    // A beat on the same edge as clear is discarded.
    cycle(1, 50, 0, 1);
    clear = 1'b1; cycle(1, 60, 0, 1); clear = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1);
    check("t5b_sum", out_sum, 4);
    cycle(0, 0, 0, 1);

    // Reset while a result is pending.
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    rst_n = 1'b0; cycle(1, 5, 0, 0); rst_n = 1'b1;
    check("t6_valid", out_valid, 0);
    check("t6_sum", out_sum, 0);

    random_run(300);

    // Narrow accumulator saturates.
    do_reset(1);
    cycle(1, 225, 0, 1);
    cycle(1, 225, 0, 1);
    cycle(1, 225, 1, 1);
    check("t3_sum", out_sum, 511);
    check("t3_count", out_count, 3);
    check("t3_ovf", out_ovf, 1);
    cycle(0, 0, 0, 1);
    random_run(200);

    // Single-beat groups.
    do_reset(2);
    cycle(1, 7, 0, 1);
    check("len1_first", out_sum, 7);
    cycle(1, 9, 0, 1);   // refused: result 7 drains this edge
    cycle(1, 9, 0, 1);
    check("len1_second", out_sum, 9);
    check("len1_count", out_count, 1);
    random_run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
